regfile_wb_scheduler: RTL and testbench

Write-port scheduler and scoreboard for the 32 x 64-bit register file in the 5-stage pipeline. It merges two writeback sources onto the single register-file write port (RegWrite, WriteRegister, WriteData): the in-order pipeline WB stage and a long-latency (multicycle) unit. It tracks long-latency destinations in a 32-bit busy scoreboard and stalls decode on RAW/WAW hazards against pending long-latency results. It sits between the WB stage, the multicycle unit and registerfile, with its stall output feeding the decode/issue stage.

---
 rtl/regfile_wb_scheduler.sv | 155 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: merges pipeline WB and multicycle results onto the single register-file
// write port, tracks pending long-latency destinations and stalls decode on hazards. Rev 1.0
`default_nettype none

module regfile_wb_scheduler #(
   parameter int DATA_W       = 64,
   parameter int ZERO_REG     = 31,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rs1,
   input  logic [4:0]        issue_rs2,
   input  logic              issue_uses_rs1,
   input  logic              issue_uses_rs2,
   input  logic [4:0]        issue_rd,
   input  logic              issue_writes,
   input  logic              issue_long,
   output logic              stall,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mc_valid,
   output logic              mc_ready,
   input  logic [4:0]        mc_rd,
   input  logic [DATA_W-1:0] mc_data,
   output logic              RegWrite,
   output logic [4:0]        WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       busy
);

   localparam logic [4:0] c_ZERO_IDX   = 5'(ZERO_REG);
   localparam logic [3:0] c_LIMIT      = 4'(STARVE_LIMIT);
   localparam logic [0:0] c_RUN        = 1'b0;
   localparam logic [0:0] c_THROTTLE   = 1'b1;

   logic [31:0]       busy_q, busy_d;
   logic              hold_full_q, hold_full_d;
   logic [4:0]        hold_rd_q, hold_rd_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic              wr_en_q, wr_en_d;
   logic [4:0]        wr_rd_q, wr_rd_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [0:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;

   logic w_wb_win, w_drain, w_accept, w_hazard, w_throttle, w_issue_set;

   assign w_wb_win = wb_valid && (wb_rd != c_ZERO_IDX);
   assign w_drain  = hold_full_q && !w_wb_win;
   assign w_accept = mc_valid && !hold_full_q;
   assign mc_ready = !hold_full_q;

   // Hazards look only at registered busy; a same-edge clear is not bypassed.
   assign w_hazard = (issue_uses_rs1 && busy_q[issue_rs1]) ||
                     (issue_uses_rs2 && busy_q[issue_rs2]) ||
                     (issue_writes   && busy_q[issue_rd]);
   assign stall       = issue_valid && (w_hazard || w_throttle);
   assign w_issue_set = issue_valid && !stall && issue_writes && issue_long &&
                        (issue_rd != c_ZERO_IDX);

   always_comb begin
      hold_full_d = hold_full_q;
      hold_rd_d   = hold_rd_q;
      hold_data_d = hold_data_q;
      if (w_drain) begin
         hold_full_d = 1'b0;
      end else if (w_accept && (mc_rd != c_ZERO_IDX)) begin
         hold_full_d = 1'b1;
         hold_rd_d   = mc_rd;
         hold_data_d = mc_data;
      end

      wr_en_d   = w_wb_win || w_drain;
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      if (w_wb_win) begin
         wr_rd_d   = wb_rd;
         wr_data_d = wb_data;
      end else if (w_drain) begin
         wr_rd_d   = hold_rd_q;
         wr_data_d = hold_data_q;
      end

      busy_d = busy_q;
      if (w_drain)
         busy_d[hold_rd_q] = 1'b0;
      if (w_issue_set)
         busy_d[issue_rd] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         c_RUN: begin
            if (hold_full_q && w_wb_win) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == c_LIMIT)
                  state_d = c_THROTTLE;
            end else begin
               cnt_d = 4'd0;
            end
         end
         c_THROTTLE: begin
            if (w_drain) begin
               state_d = c_RUN;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = c_RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      w_throttle = (state_q == c_THROTTLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q      <= '0;
         hold_full_q <= 1'b0;
         hold_rd_q   <= '0;
         hold_data_q <= '0;
         wr_en_q     <= 1'b0;
         wr_rd_q     <= '0;
         wr_data_q   <= '0;
         state_q     <= c_RUN;
         cnt_q       <= 4'd0;
      end else begin
         busy_q      <= busy_d;
         hold_full_q <= hold_full_d;
         hold_rd_q   <= hold_rd_d;
         hold_data_q <= hold_data_d;
         wr_en_q     <= wr_en_d;
         wr_rd_q     <= wr_rd_d;
         wr_data_q   <= wr_data_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
      end
   end

   assign RegWrite      = wr_en_q;
   assign WriteRegister = wr_rd_q;
   assign WriteData     = wr_data_q;
   assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed and random stimulus against a queue-based reference model
// of the write-port scheduler. Rev 1.0
`default_nettype none

module tb_regfile_wb_scheduler;

   localparam int DATA_W       = 64;
   localparam int ZERO_REG     = 31;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              issue_valid = 0, issue_uses_rs1 = 0, issue_uses_rs2 = 0;
   logic              issue_writes = 0, issue_long = 0;
   logic [4:0]        issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0;
   logic              stall;
   logic              wb_valid = 0;
   logic [4:0]        wb_rd = 0;
   logic [DATA_W-1:0] wb_data = 0;
   logic              mc_valid = 0;
   logic              mc_ready;
   logic [4:0]        mc_rd = 0;
   logic [DATA_W-1:0] mc_data = 0;
   logic              RegWrite;
   logic [4:0]        WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic [31:0]       busy;

   always #5 clk = ~clk;

   regfile_wb_scheduler #(
      .DATA_W(DATA_W), .ZERO_REG(ZERO_REG), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
      .issue_rd(issue_rd), .issue_writes(issue_writes), .issue_long(issue_long),
      .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .busy(busy)
   );

   typedef struct packed {
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } wr_t;

   // Reference model: pending multicycle results as a queue, expected writes as a scoreboard.
   wr_t         exp_wr_q[$];
   wr_t         held_q[$];
   logic [31:0] m_busy = '0;
   int          m_wait = 0;
   wr_t         m_last = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic m_stall();
      logic haz;
      haz = (issue_uses_rs1 && m_busy[issue_rs1]) || (issue_uses_rs2 && m_busy[issue_rs2]) ||
            (issue_writes && m_busy[issue_rd]);
      return issue_valid && (haz || (m_wait >= STARVE_LIMIT));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_wr_q.delete();
         held_q.delete();
         m_busy = '0;
         m_wait = 0;
         m_last = '0;
      end else begin : model_step
         logic st, had;
         wr_t  h;
         st  = m_stall();
         had = (held_q.size() != 0);
         if (wb_valid && wb_rd != 5'(ZERO_REG)) begin
            h = '{rd: wb_rd, data: wb_data};
            exp_wr_q.push_back(h);
            m_last = h;
            if (had) m_wait++;
         end else if (had) begin
            h = held_q.pop_front();
            exp_wr_q.push_back(h);
            m_last = h;
            m_busy[h.rd] = 1'b0;
            m_wait = 0;
         end else begin
            m_wait = 0;
         end
         if (mc_valid && !had && mc_rd != 5'(ZERO_REG))
            held_q.push_back('{rd: mc_rd, data: mc_data});
         if (issue_valid && !st && issue_writes && issue_long && issue_rd != 5'(ZERO_REG))
            m_busy[issue_rd] = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic exp_en;
      wr_t  e;
      chk("stall", 64'(stall), 64'(m_stall()));
      chk("mc_ready", 64'(mc_ready), 64'(held_q.size() == 0));
      chk("busy", 64'(busy), 64'(m_busy));
      exp_en = (exp_wr_q.size() != 0);
      chk("RegWrite", 64'(RegWrite), 64'(exp_en));
      if (exp_en) begin
         e = exp_wr_q.pop_front();
         chk("WriteRegister", 64'(WriteRegister), 64'(e.rd));
         chk("WriteData", WriteData, e.data);
      end else begin
         chk("WriteRegister_hold", 64'(WriteRegister), 64'(m_last.rd));
         chk("WriteData_hold", WriteData, m_last.data);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes = 0; issue_long = 0;
      issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
      wb_valid = 0; mc_valid = 0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                        input logic wr, input logic lng);
      issue_valid = 1; issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = 0; issue_uses_rs2 = 0;
      issue_rd = rd; issue_writes = wr; issue_long = lng;
   endtask

   function automatic logic [4:0] rnd_reg();
      if ($urandom_range(0, 9) == 0) return 5'(ZERO_REG);
      return 5'($urandom_range(0, 11));
   endfunction

   task automatic rnd_cycle(input bit burst);
      int cand[$];
      issue_valid    = ($urandom_range(0, 9) < 6);
      issue_rs1      = rnd_reg();
      issue_rs2      = rnd_reg();
      issue_rd       = rnd_reg();
      issue_uses_rs1 = 1'($urandom_range(0, 1));
      issue_uses_rs2 = 1'($urandom_range(0, 1));
      issue_writes   = ($urandom_range(0, 3) != 0);
      issue_long     = ($urandom_range(0, 2) == 0);
      wb_valid       = burst ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 4);
      wb_rd          = rnd_reg();
      wb_data        = {$urandom, $urandom};
      mc_valid       = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < 32; i++)
         if (m_busy[i]) cand.push_back(i);
      mc_rd   = (cand.size() != 0 && $urandom_range(0, 3) != 0) ?
                5'(cand[$urandom_range(0, cand.size() - 1)]) : rnd_reg();
      mc_data = {$urandom, $urandom};
   endtask

   initial begin
      bit burst;
      burst = 0;
      cyc(2);
      chk("rst_RegWrite", 64'(RegWrite), 64'd0);
      chk("rst_WriteRegister", 64'(WriteRegister), 64'd0);
      chk("rst_WriteData", WriteData, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mc_ready", 64'(mc_ready), 64'd1);
      chk("rst_stall", 64'(stall), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc(2);

      // Long op to X5, dependent read, then its result returns.
      issue(5'd0, 0, 5'd5, 1, 1);                    cyc();
      issue(5'd5, 1, 5'd1, 1, 0);                    cyc(3);
      mc_valid = 1; mc_rd = 5'd5; mc_data = 64'hA5; cyc();
      mc_valid = 0;                                  cyc(4);
      idle();

      // Simultaneous WB and multicycle result.
      wb_valid = 1; wb_rd = 5'd3; wb_data = 64'h33;
      mc_valid = 1; mc_rd = 5'd7; mc_data = 64'h77;  cyc();
      idle();                                        cyc(3);

      // Starvation: held result loses to continuous WB.
      issue(5'd0, 0, 5'd6, 1, 1);                    cyc();
      idle();
      mc_valid = 1; mc_rd = 5'd6; mc_data = 64'h66;
      wb_valid = 1; wb_rd = 5'd1; wb_data = 64'h11;  cyc();
      mc_valid = 0;
      issue(5'd2, 1, 5'd4, 1, 0);
      for (int i = 0; i < 8; i++) begin
         wb_rd = 5'($urandom_range(0, 30)); wb_data = {$urandom, $urandom}; cyc();
      end
      wb_valid = 0;                                  cyc(4);
      idle();

      // Hardwired-zero register everywhere.
      wb_valid = 1; wb_rd = 5'd31; wb_data = 64'hFF;
      mc_valid = 1; mc_rd = 5'd31; mc_data = 64'hEE;
      issue(5'd0, 0, 5'd31, 1, 1);                   cyc();
      idle();
      issue(5'd31, 1, 5'd31, 1, 0);                  cyc(3);
      idle();

      // WAW on X9.
      issue(5'd0, 0, 5'd9, 1, 1);                    cyc();
      cyc(3);
      mc_valid = 1; mc_rd = 5'd9; mc_data = 64'h99;  cyc();
      mc_valid = 0;                                  cyc(3);
      idle();
      mc_valid = 1; mc_rd = 5'd9; mc_data = 64'h999; cyc();
      idle();                                        cyc(3);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 29) == 0) burst = !burst;
         rnd_cycle(burst);
         cyc();
      end
      idle();                                        cyc(4);

      // Asynchronous reset while the hold entry is full.
      issue(5'd0, 0, 5'd5, 1, 1);                    cyc();
      idle();
      mc_valid = 1; mc_rd = 5'd5; mc_data = 64'h55;
      wb_valid = 1; wb_rd = 5'd2; wb_data = 64'h22;  cyc();
      mc_valid = 0;                                  cyc();
      chk("pre_reset_mc_ready", 64'(mc_ready), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("async_mc_ready", 64'(mc_ready), 64'd1);
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_RegWrite", 64'(RegWrite), 64'd0);
      idle();                                        cyc(2);
      @(negedge clk);
      reset = 1'b1;
      cyc(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
